// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm trigger stage (alarm_ring).
//   - state_e      : ring FSM states (SNOOZE exists only with ALARM_SNOOZE_EN)
//   - DIGIT_W      : bits per time digit byte
//   - DIGITS       : digits per time word {H tens, H ones, M tens, M ones}
//   - *_MS_DEF     : default durations in 1 kHz cycles
//   - digit_nibble : BCD value (low nibble) of one digit byte, index 0 = M ones
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  localparam int unsigned DIGIT_W = 8;
  localparam int unsigned DIGITS  = 4;

  localparam int unsigned RING_MS_DEF   = 60000;
  localparam int unsigned BEEP_MS_DEF   = 500;
  localparam int unsigned SNOOZE_MS_DEF = 300000;

  // Upper nibble of each digit byte carries no information and is dropped.
  function automatic logic [3:0] digit_nibble(input logic [DIGIT_W*DIGITS-1:0] word,
                                              input int unsigned               idx);
    logic [DIGIT_W*DIGITS-1:0] shifted;
    shifted = word >> (idx * DIGIT_W);
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/rise_det.sv
// -----------------------------------------------------------------------------
// rise_det
// One-cycle rising-edge detector: registers the input and flags sig & ~sig_q.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (history register clears to 0)
//   sig_i  : level input
//   rise_o : high for the cycle in which sig_i is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/alarm_ring.sv
// -----------------------------------------------------------------------------
// alarm_ring
// Alarm trigger stage feeding mode_ctl. Compares the running HH:MM time with
// the stored alarm time; on a fresh match it rings for RING_MS cycles, driving
// a 500 Hz buzzer tone gated by a BEEP_MS on / BEEP_MS off pattern.
//
// Optional feature: define ALARM_SNOOZE_EN to add a SNOOZE state that silences
// the ring for SNOOZE_MS cycles and then rings again. Without it the FSM has
// only IDLE/RINGING and the snooze input is ignored.
//
// Ports:
//   clk_1khz      : 1 kHz system tick
//   rst_n         : asynchronous active-low reset
//   arm           : alarm enabled (level)
//   time_in       : current time, 4 digit bytes, digit value in bits [3:0]
//   alarm_in      : alarm time, same format
//   stop          : debounced stop button (level, edge detected here)
//   snooze        : debounced snooze button (level, edge detected here)
//   alarm_ringing : high while RINGING
//   buzzer        : tone output, 0 outside the on phase of the beep pattern
// -----------------------------------------------------------------------------
module alarm_ring
  import alarm_pkg::*;
#(
  parameter int unsigned RING_MS   = RING_MS_DEF,
  parameter int unsigned BEEP_MS   = BEEP_MS_DEF,
  parameter int unsigned SNOOZE_MS = SNOOZE_MS_DEF
) (
  input  logic                      clk_1khz,
  input  logic                      rst_n,
  input  logic                      arm,
  input  logic [DIGIT_W*DIGITS-1:0] time_in,
  input  logic [DIGIT_W*DIGITS-1:0] alarm_in,
  input  logic                      stop,
  input  logic                      snooze,
  output logic                      alarm_ringing,
  output logic                      buzzer
);

  localparam int unsigned RING_W = $clog2(RING_MS + 1);
  localparam int unsigned BEEP_W = $clog2(2 * BEEP_MS + 1);

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MS - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(2 * BEEP_MS - 1);
  localparam logic [BEEP_W-1:0] BEEP_ON   = BEEP_W'(BEEP_MS);

  state_e            state_q;
  logic [RING_W-1:0] ring_cnt_q;
  logic [BEEP_W-1:0] beep_cnt_q;
  logic [BEEP_W-1:0] beep_cnt_d;
  logic              ringing_q;
  logic              buzzer_q;

  logic digits_eq;
  logic match;
  logic match_rise;
  logic stop_rise;
  logic snooze_rise;
  logic tone_on_d;

  // ---------------------------------------------------------------------------
  // HH:MM comparison on the low nibble of every digit byte
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    digits_eq = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_nibble(time_in, i) != digit_nibble(alarm_in, i)) begin
        digits_eq = 1'b0;
      end
    end
  end

  // Gating with arm makes disarm clear the match history, so re-arming inside
  // a matching minute produces a fresh rising edge.
  assign match = arm & digits_eq;

  rise_det u_match_rise (
    .clk    (clk_1khz),
    .rst_n  (rst_n),
    .sig_i  (match),
    .rise_o (match_rise)
  );

  rise_det u_stop_rise (
    .clk    (clk_1khz),
    .rst_n  (rst_n),
    .sig_i  (stop),
    .rise_o (stop_rise)
  );

  rise_det u_snooze_rise (
    .clk    (clk_1khz),
    .rst_n  (rst_n),
    .sig_i  (snooze),
    .rise_o (snooze_rise)
  );

  // Beep pattern position for the next ringing cycle; the tone toggles only
  // while that position lies in the on half.
  assign beep_cnt_d = (beep_cnt_q == BEEP_LAST) ? '0 : beep_cnt_q + BEEP_W'(1);
  assign tone_on_d  = (beep_cnt_d < BEEP_ON);

  // Upper nibbles of the digit bytes carry no information.
  logic unused_upper;
  assign unused_upper = ^{time_in & 32'hF0F0_F0F0, alarm_in & 32'hF0F0_F0F0};

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned           SNOOZE_W    = $clog2(SNOOZE_MS + 1);
  localparam logic [SNOOZE_W-1:0]   SNOOZE_LAST = SNOOZE_W'(SNOOZE_MS - 1);
  logic [SNOOZE_W-1:0]              snooze_cnt_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze_rise ^ SNOOZE_MS[0];
`endif

  // ---------------------------------------------------------------------------
  // Ring FSM with registered outputs. Entering RINGING (from IDLE or SNOOZE)
  // restarts both counters and sets the buzzer for the first on cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ring_cnt_q   <= '0;
      beep_cnt_q   <= '0;
      ringing_q    <= 1'b0;
      buzzer_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // Stop/snooze edges are meaningless here and are dropped.
          if (match_rise) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
            beep_cnt_q <= '0;
            ringing_q  <= 1'b1;
            buzzer_q   <= 1'b1;
          end
        end

        RINGING: begin
          // Stop has priority over snooze; further match edges are ignored.
          if (stop_rise || (ring_cnt_q == RING_LAST) || !arm) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            beep_cnt_q <= '0;
            ringing_q  <= 1'b0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_rise) begin
            state_q      <= SNOOZE;
            snooze_cnt_q <= '0;
            ring_cnt_q   <= '0;
            beep_cnt_q   <= '0;
            ringing_q    <= 1'b0;
            buzzer_q     <= 1'b0;
`endif
          end else begin
            ring_cnt_q <= ring_cnt_q + RING_W'(1);
            beep_cnt_q <= beep_cnt_d;
            buzzer_q   <= tone_on_d ? ~buzzer_q : 1'b0;
          end
        end

`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop_rise || !arm) begin
            state_q      <= IDLE;
            snooze_cnt_q <= '0;
          end else if (snooze_cnt_q == SNOOZE_LAST) begin
            state_q      <= RINGING;
            snooze_cnt_q <= '0;
            ring_cnt_q   <= '0;
            beep_cnt_q   <= '0;
            ringing_q    <= 1'b1;
            buzzer_q     <= 1'b1;
          end else begin
            snooze_cnt_q <= snooze_cnt_q + SNOOZE_W'(1);
          end
        end
`endif

        default: begin
          state_q    <= IDLE;
          ring_cnt_q <= '0;
          beep_cnt_q <= '0;
          ringing_q  <= 1'b0;
          buzzer_q   <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_ringing = ringing_q;
  assign buzzer        = buzzer_q;

endmodule

// File: tb/tb_alarm_ring.sv
// -----------------------------------------------------------------------------
// tb_alarm_ring
// Directed sequence followed by a random phase, all checked cycle by cycle
// against a reference model that tracks how long the alarm has been ringing
// (or snoozing) and derives the expected outputs arithmetically.
// -----------------------------------------------------------------------------
module tb_alarm_ring;

  localparam int RING = 20;
  localparam int BEEP = 3;
  localparam int SNZ  = 10;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif

  localparam logic [31:0] T_1234 = 32'h0102_0304;
  localparam logic [31:0] T_1235 = 32'h0102_0305;
  localparam logic [31:0] T_1236 = 32'h0102_0306;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        stop;
  logic        snooze;
  logic [31:0] time_in;
  logic [31:0] alarm_in;
  logic        alarm_ringing;
  logic        buzzer;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles since ringing / snoozing began, -1 when not.
  int ring_age;
  int snooze_age;
  bit prev_match;
  bit prev_stop;
  bit prev_snooze;

  alarm_ring #(
    .RING_MS   (RING),
    .BEEP_MS   (BEEP),
    .SNOOZE_MS (SNZ)
  ) dut (
    .clk_1khz      (clk),
    .rst_n         (rst_n),
    .arm           (arm),
    .time_in       (time_in),
    .alarm_in      (alarm_in),
    .stop          (stop),
    .snooze        (snooze),
    .alarm_ringing (alarm_ringing),
    .buzzer        (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit time_match();
    for (int k = 0; k < 4; k++) begin
      if (((time_in >> (8 * k)) & 32'hF) != ((alarm_in >> (8 * k)) & 32'hF)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit exp_ring();
    return ring_age >= 0;
  endfunction

  // Tone is high on even cycles of each on half, silent in the off half.
  function automatic bit exp_buzz();
    int p;
    if (ring_age < 0) return 1'b0;
    p = ring_age % (2 * BEEP);
    return (p < BEEP) && (p % 2 == 0);
  endfunction

  task automatic model_reset();
    ring_age    = -1;
    snooze_age  = -1;
    prev_match  = 1'b0;
    prev_stop   = 1'b0;
    prev_snooze = 1'b0;
  endtask

  task automatic model_clock();
    bit m, mr, sr, zr;
    m  = arm && time_match();
    mr = m && !prev_match;
    sr = stop && !prev_stop;
    zr = snooze && !prev_snooze;
    if (ring_age >= 0) begin
      if (sr || ring_age == RING - 1 || !arm) begin
        ring_age = -1;
      end else if (SNOOZE_EN && zr) begin
        ring_age   = -1;
        snooze_age = 0;
      end else begin
        ring_age++;
      end
    end else if (snooze_age >= 0) begin
      if (sr || !arm) begin
        snooze_age = -1;
      end else if (snooze_age == SNZ - 1) begin
        snooze_age = -1;
        ring_age   = 0;
      end else begin
        snooze_age++;
      end
    end else if (mr) begin
      ring_age = 0;
    end
    prev_match  = m;
    prev_stop   = stop;
    prev_snooze = snooze;
  endtask

  // Advance one clock: model sees the same pre-edge inputs as the DUT, then
  // outputs are compared 1 time unit after the edge.
  task automatic step(input string tag);
    if (!rst_n) model_reset();
    else        model_clock();
    @(posedge clk);
    #1;
    check({tag, "/ring"}, {31'd0, alarm_ringing}, {31'd0, exp_ring()});
    check({tag, "/buzz"}, {31'd0, buzzer},        {31'd0, exp_buzz()});
  endtask

  // Force a fresh match edge by leaving the alarm minute for one cycle.
  task automatic retrigger();
    time_in = T_1235;
    step("retrig_off");
    time_in = T_1234;
    step("retrig_on");
  endtask

  int           n_high;
  int           n_low;
  logic [11:0]  pat;
  logic [31:0]  pick;

  initial begin
    rst_n    = 1'b0;
    arm      = 1'b0;
    stop     = 1'b0;
    snooze   = 1'b0;
    time_in  = '0;
    alarm_in = '0;
    model_reset();

    // Reset state
    repeat (3) step("reset");
    check("reset_ring", {31'd0, alarm_ringing}, 32'd0);
    check("reset_buzz", {31'd0, buzzer}, 32'd0);
    rst_n = 1'b1;

    // Basic trigger; upper nibbles of time_in differ from alarm_in
    arm      = 1'b1;
    alarm_in = T_1234;
    time_in  = 32'h0102_0303;
    repeat (5) step("idle_pre");
    time_in = 32'h3132_3334;
    step("trig");
    check("trig_latency", {31'd0, alarm_ringing}, 32'd1);

    // Duration, beep pattern and no re-trigger while the match holds
    n_high = 1;
    pat    = '0;
    pat[0] = buzzer;
    for (int i = 1; i < 40; i++) begin
      step("hold");
      if (alarm_ringing) n_high++;
      if (i < 12) pat[i] = buzzer;
    end
    check("ring_len", n_high, RING);
    check("beep_pattern", {20'd0, pat}, 32'h145);
    check("no_retrigger", {31'd0, alarm_ringing}, 32'd0);

    // Leave and return to the minute -> rings again; stop at ring cycle 7
    retrigger();
    check("retrig_ring", {31'd0, alarm_ringing}, 32'd1);
    repeat (7) step("pre_stop");
    stop = 1'b1;
    step("stop");
    check("stop_ring", {31'd0, alarm_ringing}, 32'd0);
    check("stop_buzz", {31'd0, buzzer}, 32'd0);
    stop = 1'b0;
    step("stop_rel");

    // Stop edge in IDLE has no effect
    stop = 1'b1;
    repeat (2) step("stop_idle");
    stop = 1'b0;
    repeat (2) step("stop_idle_rel");
    check("stop_idle", {31'd0, alarm_ringing}, 32'd0);

    // Disarm during ring, re-arm inside the matching minute
    retrigger();
    repeat (3) step("pre_disarm");
    arm = 1'b0;
    step("disarm");
    check("disarm", {31'd0, alarm_ringing}, 32'd0);
    arm = 1'b1;
    step("rearm");
    check("rearm", {31'd0, alarm_ringing}, 32'd1);

    // Asynchronous reset at ring cycle 10
    repeat (10) step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_ring", {31'd0, alarm_ringing}, 32'd0);
    check("async_rst_buzz", {31'd0, buzzer}, 32'd0);
    time_in = T_1236;
    step("in_rst");
    rst_n = 1'b1;
    repeat (5) step("post_rst");
    check("post_rst_idle", {31'd0, alarm_ringing}, 32'd0);
    time_in = T_1234;
    step("post_rst_match");
    check("post_rst_ring", {31'd0, alarm_ringing}, 32'd1);
    stop = 1'b1;
    step("post_rst_stop");
    stop = 1'b0;
    step("post_rst_stop_rel");

`ifdef ALARM_SNOOZE_EN
    // Snooze at ring cycle 4: silent for SNZ cycles, then a full ring
    retrigger();
    repeat (4) step("pre_snooze");
    snooze = 1'b1;
    step("snooze");
    snooze = 1'b0;
    n_low  = 1;
    n_high = 0;
    for (int i = 0; i < 40; i++) begin
      step("snoozing");
      if (alarm_ringing) n_high++;
      else if (n_high == 0) n_low++;
    end
    check("snooze_low", n_low, SNZ);
    check("snooze_ring", n_high, RING);

    // Stop during snooze -> IDLE, no re-ring
    retrigger();
    repeat (2) step("pre_snooze2");
    snooze = 1'b1;
    step("snooze2");
    snooze = 1'b0;
    repeat (3) step("snooze2_wait");
    stop = 1'b1;
    step("snooze_stop");
    stop = 1'b0;
    repeat (12) step("snooze_stop_wait");
    check("snooze_stop", {31'd0, alarm_ringing}, 32'd0);

    // Stop and snooze together -> stop wins
    retrigger();
    repeat (3) step("pre_both");
    stop   = 1'b1;
    snooze = 1'b1;
    step("both");
    check("both_ring", {31'd0, alarm_ringing}, 32'd0);
    stop   = 1'b0;
    snooze = 1'b0;
    repeat (12) step("both_wait");
    check("both_idle", {31'd0, alarm_ringing}, 32'd0);
`else
    // Without the snooze feature a snooze edge leaves the ring running
    retrigger();
    repeat (4) step("pre_snooze");
    snooze = 1'b1;
    step("snooze");
    check("snooze_ignored", {31'd0, alarm_ringing}, 32'd1);
    snooze = 1'b0;
    stop   = 1'b1;
    step("snooze_stop");
    check("snooze_stop", {31'd0, alarm_ringing}, 32'd0);
    stop = 1'b0;
    step("snooze_stop_rel");
`endif

    // Random phase
    for (int i = 0; i < 800; i++) begin
      if (!arm) arm = ($urandom_range(0, 3) == 0);
      else      arm = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    pick = T_1234;
          2:       pick = T_1235;
          default: pick = 32'h0102_0434;
        endcase
        time_in = pick | ($urandom & 32'hF0F0_F0F0);
      end
      stop   = ($urandom_range(0, 19) == 0);
      snooze = ($urandom_range(0, 14) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
